// File: rtl/ttt_btn_cond.sv
// Input conditioner for the six tic-tac-toe buttons.
// Each channel does a 2-FF synchroniser, a restartable debounce counter,
// a registered press pulse and (on direction buttons) an auto-repeat FSM.

module ttt_btn_cond_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter int unsigned CNT_W           = 26,
  parameter bit          RPT_EN          = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);
  // state    | meaning
  // ST_IDLE  | button released or pulse already given, no repeat pending
  // ST_DELAY | held after press, counting towards the first repeat
  // ST_RPT   | held past first repeat, counting the repeat period
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RPT} rpt_state_e;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  rpt_state_e       state_q, state_d;
  logic             rpt_pulse;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES differing samples in a row.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    press_d  = 1'b0;
    if (s2_q != stable_q) begin
      if (dcnt_q == DB_LAST) begin
        stable_d = s2_q;
        press_d  = s2_q;
      end else begin
        dcnt_d = dcnt_q + CNT_ONE;
      end
    end
  end

  // Auto-repeat: release (stable low) always wins and returns to idle without a pulse.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rpt_pulse = 1'b0;
    if (!RPT_EN || !stable_q) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_q) begin
            state_d = ST_DELAY;
            rcnt_d  = '0;
          end
        end
        ST_DELAY: begin
          if (rcnt_q == DLY_LAST) begin
            rpt_pulse = 1'b1;
            rcnt_d    = '0;
            state_d   = ST_RPT;
          end else begin
            rcnt_d = rcnt_q + CNT_ONE;
          end
        end
        ST_RPT: begin
          if (rcnt_q == PER_LAST) begin
            rpt_pulse = 1'b1;
            rcnt_d    = '0;
          end else begin
            rcnt_d = rcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Debounce and repeat state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      state_q  <= ST_IDLE;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      state_q  <= state_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = press_q | rpt_pulse;
endmodule

module ttt_btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       enter_raw,
  input  logic       space_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       space,
  output logic [5:0] btn_level
);
  logic [5:0] raw_vec;
  logic [5:0] pulse_vec;

  // Counters compare with ==, so every terminal count must be representable in CNT_W bits.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      (64'(DEBOUNCE_CYCLES) >> CNT_W) != 0 ||
      (64'(REPEAT_DELAY) >> CNT_W) != 0 ||
      (64'(REPEAT_PERIOD) >> CNT_W) != 0) begin : g_cfg_err
    $error("ttt_btn_cond: parameters out of range for CNT_W");
  end

  assign raw_vec = {space_raw, enter_raw, right_raw, left_raw, down_raw, up_raw};

  // Bits 0..3 are the direction buttons and may repeat; enter and space never do.
  for (genvar i = 0; i < 6; i++) begin : g_chan
    ttt_btn_cond_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W),
      .RPT_EN         (REPEAT_EN && (i < 4))
    ) u_chan (
      .clk_i  (clk),
      .rst_i  (reset),
      .raw_i  (raw_vec[i]),
      .level_o(btn_level[i]),
      .pulse_o(pulse_vec[i])
    );
  end

  assign up    = pulse_vec[0];
  assign down  = pulse_vec[1];
  assign left  = pulse_vec[2];
  assign right = pulse_vec[3];
  assign enter = pulse_vec[4];
  assign space = pulse_vec[5];
endmodule

// File: tb/tb_ttt_btn_cond.sv
// Directed bench for ttt_btn_cond with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Edge numbers count rising clk edges after the raw pins are set; "edge k" means sampled 1 ns after it.
// Bit order everywhere: {space,enter,right,left,down,up}.

module tb_ttt_btn_cond;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] raw_v = '0;
  logic       up, down, left, right, enter, space;
  logic [5:0] btn_level;
  logic       up2, down2, left2, right2, enter2, space2;
  logic [5:0] btn_level2;
  logic [5:0] pulse, pulse2;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign pulse  = {space, enter, right, left, down, up};
  assign pulse2 = {space2, enter2, right2, left2, down2, up2};

  ttt_btn_cond #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10),
                 .REPEAT_PERIOD(5), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .up_raw(raw_v[0]), .down_raw(raw_v[1]), .left_raw(raw_v[2]),
    .right_raw(raw_v[3]), .enter_raw(raw_v[4]), .space_raw(raw_v[5]),
    .up(up), .down(down), .left(left), .right(right), .enter(enter), .space(space),
    .btn_level(btn_level)
  );

  ttt_btn_cond #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10),
                 .REPEAT_PERIOD(5), .CNT_W(8)) dut_norpt (
    .clk(clk), .reset(reset),
    .up_raw(raw_v[0]), .down_raw(raw_v[1]), .left_raw(raw_v[2]),
    .right_raw(raw_v[3]), .enter_raw(raw_v[4]), .space_raw(raw_v[5]),
    .up(up2), .down(down2), .left(left2), .right(right2), .enter(enter2), .space(space2),
    .btn_level(btn_level2)
  );

  typedef struct {
    logic [5:0] raw;
    logic [5:0] exp_pulse;
    logic [5:0] exp_level;
  } vec_t;

  vec_t vecs[38];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] raw);
    raw_v = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    int exp_rpt[7];

    // Clean up press held 8 clk: pulse at 6, level high edges 6..13, no repeat since released early.
    for (int e = 1; e <= 18; e++) begin
      vecs[e-1].raw       = (e <= 8) ? 6'h01 : 6'h00;
      vecs[e-1].exp_pulse = (e == 6) ? 6'h01 : 6'h00;
      vecs[e-1].exp_level = (e >= 6 && e <= 13) ? 6'h01 : 6'h00;
    end
    // up and left together; left held 8 clk, up held 12 clk so its first repeat lands at 16.
    for (int e = 1; e <= 20; e++) begin
      vecs[17+e].raw       = ((e <= 8) ? 6'h04 : 6'h00) | ((e <= 12) ? 6'h01 : 6'h00);
      vecs[17+e].exp_pulse = (e == 6) ? 6'h05 : ((e == 16) ? 6'h01 : 6'h00);
      vecs[17+e].exp_level = ((e >= 6 && e <= 13) ? 6'h04 : 6'h00) |
                             ((e >= 6 && e <= 17) ? 6'h01 : 6'h00);
    end
    exp_rpt = '{6, 16, 21, 26, 31, 36, 41};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulse", {26'd0, pulse}, 32'd0);
    chk("reset_level", {26'd0, btn_level}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 38; i++) begin
      step(vecs[i].raw);
      chk($sformatf("vec%0d_pulse", i), {26'd0, pulse}, {26'd0, vecs[i].exp_pulse});
      chk($sformatf("vec%0d_level", i), {26'd0, btn_level}, {26'd0, vecs[i].exp_level});
    end

    // Bounce on enter: 1,0,1,0 every 2 clk, final rise before edge 9, held 40 clk.
    q.delete();
    for (int e = 1; e <= 60; e++) begin
      logic b;
      b = (e <= 2) || (e >= 5 && e <= 6) || (e >= 9 && e <= 48);
      step({1'b0, b, 4'b0});
      if (enter) q.push_back(e);
      if (e == 13) chk("bounce_level13", {31'd0, btn_level[4]}, 32'd0);
      if (e == 14) chk("bounce_level14", {31'd0, btn_level[4]}, 32'd1);
    end
    chk("bounce_count", q.size(), 1);
    if (q.size() > 0) chk("bounce_edge", q[0], 14);
    chk("bounce_rel_level", {26'd0, btn_level}, 32'd0);

    // space held 40 clk: one pulse, never repeats.
    q.delete();
    for (int e = 1; e <= 50; e++) begin
      step((e <= 40) ? 6'h20 : 6'h00);
      if (space) q.push_back(e);
    end
    chk("space_count", q.size(), 1);
    if (q.size() > 0) chk("space_edge", q[0], 6);

    // right held 40 clk: press at 6, first repeat at 16, then every 5 clk. Stable drops at
    // edge 46, the same cycle the next repeat is due, so that repeat is suppressed.
    q.delete();
    for (int e = 1; e <= 50; e++) begin
      step((e <= 40) ? 6'h08 : 6'h00);
      if (right) q.push_back(e);
      if (e == 45) chk("rpt_level45", {31'd0, btn_level[3]}, 32'd1);
      if (e == 46) chk("rpt_level46", {31'd0, btn_level[3]}, 32'd0);
    end
    chk("rpt_count", q.size(), 7);
    for (int i = 0; i < 7 && i < q.size(); i++)
      chk($sformatf("rpt_edge%0d", i), q[i], exp_rpt[i]);

    // Repeat disabled: up held 40 clk gives exactly one pulse.
    q.delete();
    for (int e = 1; e <= 50; e++) begin
      step((e <= 40) ? 6'h01 : 6'h00);
      if (up2) q.push_back(e);
    end
    chk("norpt_count", q.size(), 1);
    if (q.size() > 0) chk("norpt_edge", q[0], 6);

    // Reset during DELAY with down held; a fresh press follows reset release.
    for (int e = 1; e <= 10; e++) step(6'h02);
    chk("pre_reset_level", {26'd0, btn_level}, 32'h02);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_pulse", {26'd0, pulse}, 32'd0);
    chk("midrst_level", {26'd0, btn_level}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(6'h02);
      chk($sformatf("postrst_pulse%0d", e), {26'd0, pulse}, (e == 6) ? 32'h02 : 32'h00);
    end
    chk("postrst_level", {26'd0, btn_level}, 32'h02);
    for (int e = 1; e <= 12; e++) step(6'h00);
    chk("final_level", {26'd0, btn_level}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
